// File: rtl/ber_counter_pkg.sv
// Shared definitions for the BER checker: FSM state encoding and default sizing.
package ber_counter_pkg;

  localparam int NB_DELAY_DEF = 9;
  localparam int NB_CNT_DEF   = 64;
  localparam int WIN_DEF      = 511;
  localparam int LOSS_THR_DEF = 64;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } ber_state_e;

endpackage

// File: rtl/ber_delay_line.sv
// Reference-bit history with a selectable tap; tap 0 is the incoming bit itself,
// tap k is the bit shifted in k strobes earlier.
module ber_delay_line #(
  parameter int NB_DELAY = 9
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_shift,
  input  logic                i_bit,
  input  logic [NB_DELAY-1:0] i_sel,
  output logic                o_tap
);

  localparam int DEPTH = 2 ** NB_DELAY;

  // Only DEPTH-1 past bits need storage because tap 0 comes straight from i_bit.
  logic [DEPTH-2:0] sr_q, sr_d;
  logic [DEPTH-1:0] taps;

  always_comb begin
    sr_d = sr_q;
    if (i_shift) sr_d = {sr_q[DEPTH-3:0], i_bit};
  end

  always_ff @(posedge clock) begin
    if (i_reset) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  assign taps  = {sr_q, i_bit};
  assign o_tap = taps[i_sel];

endmodule

// File: rtl/ber_counter.sv
// BER checker: fills the reference history, searches for the TX->RX latency one
// window at a time, then locks and accumulates bit/error counts until lock is lost.
module ber_counter
  import ber_counter_pkg::*;
#(
  parameter int NB_DELAY = NB_DELAY_DEF,
  parameter int NB_CNT   = NB_CNT_DEF,
  parameter int WIN      = WIN_DEF,
  parameter int LOSS_THR = LOSS_THR_DEF
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_ref_bit,
  input  logic                i_rx_bit,
  output logic                o_locked,
  output logic [NB_DELAY-1:0] o_latency,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count
);

  localparam int NB_WIN = $clog2(WIN + 1);

  ber_state_e        state_q, state_d;
  logic [NB_DELAY-1:0] fill_q, fill_d;
  logic [NB_DELAY-1:0] lat_q, lat_d;
  logic [NB_WIN-1:0]   win_cnt_q, win_cnt_d;
  logic [NB_WIN-1:0]   win_err_q, win_err_d;
  logic [NB_CNT-1:0]   bit_q, bit_d;
  logic [NB_CNT-1:0]   err_q, err_d;
  logic                locked_q, locked_d;

  logic              event_w;
  logic              tap;
  logic              mismatch;
  logic              win_end;
  logic [NB_WIN-1:0] win_err_inc;

  assign event_w = i_enable & i_valid;

  ber_delay_line #(.NB_DELAY(NB_DELAY)) u_delay (
    .clock   (clock),
    .i_reset (i_reset),
    .i_shift (event_w),
    .i_bit   (i_ref_bit),
    .i_sel   (lat_q),
    .o_tap   (tap)
  );

  assign mismatch    = i_rx_bit ^ tap;
  assign win_err_inc = win_err_q + NB_WIN'(mismatch);
  assign win_end     = (win_cnt_q == NB_WIN'(WIN - 1));

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    lat_d     = lat_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    bit_d     = bit_q;
    err_d     = err_q;
    locked_d  = locked_q;
    if (event_w) begin
      unique case (state_q)
        ST_FILL: begin
          if (fill_q == '1) begin
            state_d   = ST_SEARCH;
            lat_d     = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            fill_d = fill_q + NB_DELAY'(1);
          end
        end
        ST_SEARCH: begin
          win_cnt_d = win_cnt_q + NB_WIN'(1);
          win_err_d = win_err_inc;
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_inc == '0) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              lat_d = lat_q + NB_DELAY'(1);
            end
          end
        end
        ST_LOCKED: begin
          // Both counters freeze together once the bit count saturates.
          if (bit_q != '1) begin
            bit_d = bit_q + NB_CNT'(1);
            err_d = err_q + NB_CNT'(mismatch);
          end
          win_cnt_d = win_cnt_q + NB_WIN'(1);
          win_err_d = win_err_inc;
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_err_inc >= NB_WIN'(LOSS_THR)) begin
              state_d  = ST_SEARCH;
              lat_d    = '0;
              bit_d    = '0;
              err_d    = '0;
              locked_d = 1'b0;
            end
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q   <= ST_FILL;
      fill_q    <= '0;
      lat_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      bit_q     <= '0;
      err_q     <= '0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      lat_q     <= lat_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      bit_q     <= bit_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_latency   = lat_q;
  assign o_bit_count = bit_q;
  assign o_err_count = err_q;

endmodule

// File: tb/tb_ber_counter.sv
// Bench for ber_counter: a default-size instance and a shrunken one (8 taps, 4-bit
// counts, 40-strobe windows) share the reference stream and are tracked by one model.
module tb_ber_counter;

  logic clock;
  logic i_reset, i_enable, i_valid, i_ref_bit, i_rx_bit, rx_s;

  logic        locked_m;
  logic [8:0]  lat_m;
  logic [63:0] bits_m, errs_m;
  logic        locked_s;
  logic [2:0]  lat_s;
  logic [3:0]  bits_s, errs_s;

  ber_counter u_dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit),
    .o_locked(locked_m), .o_latency(lat_m), .o_bit_count(bits_m), .o_err_count(errs_m)
  );

  ber_counter #(.NB_DELAY(3), .NB_CNT(4), .WIN(40), .LOSS_THR(4)) u_dut_s (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_ref_bit(i_ref_bit), .i_rx_bit(rx_s),
    .o_locked(locked_s), .o_latency(lat_s), .o_bit_count(bits_s), .o_err_count(errs_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (index 0 = default, 1 = small) ----------------
  int          p_depth [2];
  int          p_win   [2];
  int          p_thr   [2];
  logic [63:0] p_max   [2];

  bit          hist[$];
  int          m_mode [2];  // 0 fill, 1 search, 2 locked
  int          m_fill [2];
  int          m_lat  [2];
  int          m_wc   [2];
  int          m_we   [2];
  logic [63:0] m_bits [2];
  logic [63:0] m_errs [2];

  function automatic bit tap_of(int k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_fill[i] = 0; m_lat[i] = 0; m_wc[i] = 0; m_we[i] = 0;
      m_bits[i] = 0; m_errs[i] = 0;
    end
  endtask

  task automatic model_event(input bit ref_b, input bit rx0, input bit rx1);
    bit rx[2];
    int mis;
    rx[0] = rx0; rx[1] = rx1;
    hist.push_back(ref_b);
    for (int i = 0; i < 2; i++) begin
      if (m_mode[i] == 0) begin
        m_fill[i]++;
        if (m_fill[i] == p_depth[i]) begin
          m_mode[i] = 1; m_lat[i] = 0; m_wc[i] = 0; m_we[i] = 0;
        end
      end else begin
        mis = (rx[i] != tap_of(m_lat[i])) ? 1 : 0;
        if (m_mode[i] == 2 && m_bits[i] != p_max[i]) begin
          m_bits[i] += 1;
          m_errs[i] += 64'(mis);
        end
        m_wc[i]++;
        m_we[i] += mis;
        if (m_wc[i] == p_win[i]) begin
          if (m_mode[i] == 1) begin
            if (m_we[i] == 0) m_mode[i] = 2;
            else m_lat[i] = (m_lat[i] + 1) % p_depth[i];
          end else if (m_we[i] >= p_thr[i]) begin
            m_mode[i] = 1; m_lat[i] = 0; m_bits[i] = 0; m_errs[i] = 0;
          end
          m_wc[i] = 0; m_we[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("m_locked", 64'(locked_m), 64'(m_mode[0] == 2));
    chk("m_latency", 64'(lat_m), 64'(m_lat[0]));
    chk("m_bits", bits_m, m_bits[0]);
    chk("m_errs", errs_m, m_errs[0]);
    chk("s_locked", 64'(locked_s), 64'(m_mode[1] == 2));
    chk("s_latency", 64'(lat_s), 64'(m_lat[1]));
    chk("s_bits", 64'(bits_s), m_bits[1]);
    chk("s_errs", 64'(errs_s), m_errs[1]);
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] prbs;
  int rx_mode_m;   // 0 random, 1 delayed 5, 2 delayed 5 inverted
  int rx_mode_s;   // 0 random, 1 delayed 3, 2 delayed 3 inverted, 3 delayed 3 alternate errors
  bit flip_once;
  bit alt;

  function automatic bit prbs_step();
    bit nb;
    nb   = prbs[8] ^ prbs[4];
    prbs = {prbs[7:0], nb};
    return nb;
  endfunction

  // Called at a negedge; returns at a negedge four clocks later.
  task automatic strobe();
    bit r, a, b;
    r = i_enable ? prbs_step() : i_ref_bit;
    // Before the push, tap_of(k-1) is the reference from k events ago.
    case (rx_mode_m)
      1: a = tap_of(4);
      2: a = ~tap_of(4);
      default: a = 1'($urandom_range(0, 1));
    endcase
    if (flip_once) begin a = ~a; flip_once = 1'b0; end
    case (rx_mode_s)
      1: b = tap_of(2);
      2: b = ~tap_of(2);
      3: begin b = tap_of(2) ^ alt; alt = ~alt; end
      default: b = 1'($urandom_range(0, 1));
    endcase
    i_ref_bit = r; i_rx_bit = a; rx_s = b; i_valid = 1'b1;
    @(posedge clock);
    if (i_reset) model_reset();
    else if (i_enable) model_event(r, a, b);
    @(negedge clock);
    i_valid = 1'b0;
    check_all();
    repeat (3) @(negedge clock);
  endtask

  task automatic pulse_reset();
    i_reset = 1'b1;
    i_valid = 1'b1;
    @(posedge clock);
    model_reset();
    @(negedge clock);
    i_valid = 1'b0;
    repeat (2) @(negedge clock);
    i_reset = 1'b0;
    chk("rst_m_locked", 64'(locked_m), 0);
    chk("rst_m_latency", 64'(lat_m), 0);
    chk("rst_m_bits", bits_m, 0);
    chk("rst_m_errs", errs_m, 0);
    chk("rst_s_bits", 64'(bits_s), 0);
    chk("rst_s_latency", 64'(lat_s), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap_bits, snap_errs;
    logic [63:0] sat_err;
    int nflip;
    bit seen;

    p_depth = '{512, 8};
    p_win   = '{511, 40};
    p_thr   = '{64, 4};
    p_max   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd15};
    prbs = 9'($urandom_range(1, 511));
    rx_mode_m = 0; rx_mode_s = 0; flip_once = 1'b0; alt = 1'b0;
    i_reset = 1'b0; i_enable = 1'b1; i_valid = 1'b0; i_ref_bit = 1'b0;
    i_rx_bit = 1'b0; rx_s = 1'b0;
    model_reset();
    @(negedge clock);
    pulse_reset();

    // random traffic with random enable gaps, then a reset mid-stream
    for (int n = 0; n < 300; n++) begin
      i_enable = ($urandom_range(0, 3) != 0);
      strobe();
    end
    i_enable = 1'b1;
    pulse_reset();

    // lock on a 5-strobe latency; small instance locks on 3
    rx_mode_m = 1; rx_mode_s = 1;
    for (int n = 1; n <= 3578; n++) begin
      strobe();
      if (n == 3577) chk("lock_not_early", 64'(locked_m), 0);
    end
    chk("lock_at_3578", 64'(locked_m), 1);
    chk("lock_latency", 64'(lat_m), 5);
    chk("lock_bits0", bits_m, 0);
    chk("s_lock_latency", 64'(lat_s), 3);

    // single bit error after lock
    nflip = $urandom_range(5, 40);
    for (int n = 0; n < nflip; n++) strobe();
    flip_once = 1'b1;
    strobe();
    chk("one_err", errs_m, 1);
    chk("bits_after_flip", bits_m, 64'(nflip + 1));
    for (int n = 0; n < 20; n++) strobe();

    // enable low for 100 strobes
    snap_bits = m_bits[0]; snap_errs = m_errs[0];
    i_enable = 1'b0;
    for (int n = 0; n < 100; n++) strobe();
    chk("frz_bits", bits_m, snap_bits);
    chk("frz_errs", errs_m, snap_errs);
    chk("frz_locked", 64'(locked_m), 1);
    i_enable = 1'b1;
    for (int n = 0; n < 30; n++) strobe();
    chk("resume_bits", bits_m, snap_bits + 30);

    // polarity inversion drops lock at the window end
    rx_mode_m = 2;
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      strobe();
      if (m_mode[0] != 2) seen = 1'b1;
    end
    chk("loss_seen", 64'(seen), 1);
    chk("loss_locked", 64'(locked_m), 0);
    chk("loss_latency", 64'(lat_m), 0);
    chk("loss_bits", bits_m, 0);
    chk("loss_errs", errs_m, 0);

    // small instance: inverted search wraps 7 -> 0
    rx_mode_s = 2;
    seen = 1'b0;
    for (int n = 0; n < 500 && !seen; n++) begin
      strobe();
      if (m_mode[1] == 1 && m_lat[1] == 7) seen = 1'b1;
    end
    chk("s_reach7", 64'(lat_s), 7);
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      strobe();
      if (m_lat[1] == 0) seen = 1'b1;
    end
    chk("s_wrap", 64'(lat_s), 0);
    chk("s_wrap_unlocked", 64'(locked_s), 0);

    // relock, then 50% errors until the 4-bit counters saturate
    rx_mode_s = 1;
    seen = 1'b0;
    for (int n = 0; n < 800 && !seen; n++) begin
      strobe();
      if (m_mode[1] == 2) seen = 1'b1;
    end
    chk("s_relock", 64'(locked_s), 1);
    chk("s_relock_lat", 64'(lat_s), 3);
    rx_mode_s = 3; alt = 1'b0;
    for (int n = 0; n < 25; n++) strobe();
    chk("sat_bits", 64'(bits_s), 15);
    chk("sat_err_7_or_8", 64'(errs_s == 4'd7 || errs_s == 4'd8), 1);
    sat_err = 64'(errs_s);
    for (int n = 0; n < 5; n++) strobe();
    chk("sat_bits_hold", 64'(bits_s), 15);
    chk("sat_errs_hold", 64'(errs_s), sat_err);
    chk("main_no_relock", 64'(locked_m), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
